axi_rd_reorder_buffer: RTL and testbench

- Parametrised successor to the single-beat AXI read reorder buffer.
- Sits between an AXI read master (slave-side ports) and an out-of-order read fabric (master-side ports).
- Remaps each accepted AR ID to an internal slot tag, accepts burst R beats in any slot order, and returns bursts on the slave side in AR acceptance order, restoring the original ARID.
- Adds over the previous generation: configurable depth and ID width, bursts with RLAST, RRESP, and a sticky protocol-error flag.

---
 rtl/axi_rob_pkg.sv | 27 ++
 rtl/rob_slot_mem.sv | 39 +++
 rtl/axi_rd_reorder_buffer.sv | 141 ++++++++++++++
 tb/tb_axi_rd_reorder_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rob_pkg.sv
// Shared types and helpers for the AXI read reorder buffer.
// Slot fields are sized generously so one struct type serves every parameterisation.
package axi_rob_pkg;

  localparam int unsigned SLOT_ID_W  = 16;
  localparam int unsigned SLOT_CNT_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_ID_W-1:0]  orig_id;
    logic [SLOT_CNT_W-1:0] len;
    logic [SLOT_CNT_W-1:0] wr_beat;
    logic [SLOT_CNT_W-1:0] rd_beat;
  } slot_state_t;

  function automatic int unsigned tag_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned len_width(input int unsigned max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/rob_slot_mem.sv
// Beat storage for all slots: one write port and one combinational read port,
// addressed by {slot, beat}.
module rob_slot_mem
  import axi_rob_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 4,
  parameter  int unsigned MAX_LEN    = 4,
  localparam int unsigned TAG_W      = tag_width(DEPTH),
  localparam int unsigned LEN_W      = len_width(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [TAG_W-1:0]      wr_slot_i,
  input  logic [LEN_W-1:0]      wr_beat_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [1:0]            wr_resp_i,
  input  logic [TAG_W-1:0]      rd_slot_i,
  input  logic [LEN_W-1:0]      rd_beat_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [1:0]            rd_resp_o
);

  typedef struct packed {
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t mem_q [DEPTH*MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[{wr_slot_i, wr_beat_i}] <= '{resp: wr_resp_i, data: wr_data_i};
    end
  end

  assign {rd_resp_o, rd_data_o} = mem_q[{rd_slot_i, rd_beat_i}];

endmodule

// File: rtl/axi_rd_reorder_buffer.sv
// AXI read reorder buffer: tags each AR with a slot, collects burst beats in any
// slot order and returns whole bursts in AR acceptance order with the original ID.
module axi_rd_reorder_buffer
  import axi_rob_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned ID_WIDTH   = 4,
  parameter  int unsigned DEPTH      = 4,
  parameter  int unsigned MAX_LEN    = 4,
  localparam int unsigned TAG_W      = tag_width(DEPTH),
  localparam int unsigned LEN_W      = len_width(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic [LEN_W-1:0]      s_arlen_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic                  s_rlast_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [TAG_W-1:0]      m_arid_o,
  output logic [LEN_W-1:0]      m_arlen_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic [TAG_W-1:0]      m_rid_i,
  input  logic                  m_rlast_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  output logic                  err_o
);

  slot_state_t slot_q [DEPTH];
  slot_state_t slot_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             err_q, err_d;
  logic             live_q, live_d;

  logic full, alloc, beat_in, beat_ok, rd_hs, retire, head_avail;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [1:0]            mem_rresp;

  // AR path is a pass-through gated by occupancy; live_q keeps handshakes low in reset.
  assign full        = (count_q == (TAG_W+1)'(DEPTH));
  assign s_arready_o = live_q & m_arready_i & ~full;
  assign m_arvalid_o = live_q & s_arvalid_i & ~full;
  assign m_arid_o    = tail_q;
  assign m_arlen_o   = s_arlen_i;
  assign m_rready_o  = live_q;
  assign alloc       = s_arvalid_i & s_arready_o;

  assign beat_in = live_q & m_rvalid_i;
  assign beat_ok = slot_q[m_rid_i].valid
                && (slot_q[m_rid_i].wr_beat <= slot_q[m_rid_i].len)
                && (m_rlast_i == (slot_q[m_rid_i].wr_beat == slot_q[m_rid_i].len));

  assign head_avail = slot_q[head_q].valid
                    & (slot_q[head_q].wr_beat > slot_q[head_q].rd_beat);
  assign s_rvalid_o = head_avail;
  assign s_rlast_o  = head_avail & (slot_q[head_q].rd_beat == slot_q[head_q].len);
  assign s_rid_o    = head_avail ? slot_q[head_q].orig_id[ID_WIDTH-1:0] : '0;
  assign s_rdata_o  = head_avail ? mem_rdata : '0;
  assign s_rresp_o  = head_avail ? mem_rresp : RESP_OKAY;
  assign rd_hs      = head_avail & s_rready_i;
  assign retire     = rd_hs & s_rlast_o;
  assign err_o      = err_q;

  rob_slot_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .MAX_LEN    (MAX_LEN)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (beat_in & beat_ok),
    .wr_slot_i (m_rid_i),
    .wr_beat_i (slot_q[m_rid_i].wr_beat[LEN_W-1:0]),
    .wr_data_i (m_rdata_i),
    .wr_resp_i (m_rresp_i),
    .rd_slot_i (head_q),
    .rd_beat_i (slot_q[head_q].rd_beat[LEN_W-1:0]),
    .rd_data_o (mem_rdata),
    .rd_resp_o (mem_rresp)
  );

  // A head write and a head read touch different fields, so applying them in turn is safe.
  always_comb begin
    slot_d  = slot_q;
    head_d  = head_q;
    tail_d  = tail_q;
    err_d   = err_q;
    live_d  = 1'b1;
    if (beat_in) begin
      if (beat_ok) begin
        slot_d[m_rid_i].wr_beat = slot_q[m_rid_i].wr_beat + SLOT_CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end
    if (rd_hs) begin
      slot_d[head_q].rd_beat = slot_q[head_q].rd_beat + SLOT_CNT_W'(1);
      if (s_rlast_o) begin
        slot_d[head_q].valid = 1'b0;
        head_d               = head_q + TAG_W'(1);
      end
    end
    if (alloc) begin
      slot_d[tail_q].valid   = 1'b1;
      slot_d[tail_q].orig_id = SLOT_ID_W'(s_arid_i);
      slot_d[tail_q].len     = SLOT_CNT_W'(s_arlen_i);
      slot_d[tail_q].wr_beat = '0;
      slot_d[tail_q].rd_beat = '0;
      tail_d                 = tail_q + TAG_W'(1);
    end
    count_d = count_q + (TAG_W+1)'(alloc) - (TAG_W+1)'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      live_q  <= live_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_reorder_buffer.sv
// Self-checking bench for axi_rd_reorder_buffer (default parameters): directed
// sequences plus a table of single-beat transfers, with a slave-side scoreboard.
module tb_axi_rd_reorder_buffer;
  import axi_rob_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_arid_i;
  logic [1:0] s_arlen_i;
  logic       s_arvalid_i;
  logic       s_arready_o;
  logic [7:0] s_rdata_o;
  logic [1:0] s_rresp_o;
  logic [3:0] s_rid_o;
  logic       s_rlast_o;
  logic       s_rvalid_o;
  logic       s_rready_i;
  logic [1:0] m_arid_o;
  logic [1:0] m_arlen_o;
  logic       m_arvalid_o;
  logic       m_arready_i;
  logic [7:0] m_rdata_i;
  logic [1:0] m_rresp_i;
  logic [1:0] m_rid_i;
  logic       m_rlast_i;
  logic       m_rvalid_i;
  logic       m_rready_o;
  logic       err_o;

  always #5 clk = ~clk;

  axi_rd_reorder_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_arid_i    (s_arid_i),
    .s_arlen_i   (s_arlen_i),
    .s_arvalid_i (s_arvalid_i),
    .s_arready_o (s_arready_o),
    .s_rdata_o   (s_rdata_o),
    .s_rresp_o   (s_rresp_o),
    .s_rid_o     (s_rid_o),
    .s_rlast_o   (s_rlast_o),
    .s_rvalid_o  (s_rvalid_o),
    .s_rready_i  (s_rready_i),
    .m_arid_o    (m_arid_o),
    .m_arlen_o   (m_arlen_o),
    .m_arvalid_o (m_arvalid_o),
    .m_arready_i (m_arready_i),
    .m_rdata_i   (m_rdata_i),
    .m_rresp_i   (m_rresp_i),
    .m_rid_i     (m_rid_i),
    .m_rlast_i   (m_rlast_i),
    .m_rvalid_i  (m_rvalid_i),
    .m_rready_o  (m_rready_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [3:0] id;
    logic [7:0] data;
    logic [1:0] resp;
    logic [1:0] tag;
  } vec_t;

  beat_t exp_q[$];
  vec_t  tbl[4];
  int    n_pass = 0;
  int    n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] id, input logic [7:0] data,
                          input logic [1:0] resp, input logic last);
    exp_q.push_back('{id: id, resp: resp, last: last, data: data});
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [1:0] len, input logic [1:0] etag);
    bit done = 1'b0;
    s_arid_i    = id;
    s_arlen_i   = len;
    s_arvalid_i = 1'b1;
    #1;
    for (int k = 0; k < 40 && !done; k++) begin
      if (s_arready_o) begin
        chk("m_arid", 32'(m_arid_o), 32'(etag));
        chk("m_arlen", 32'(m_arlen_o), 32'(len));
        chk("m_arvalid", 32'(m_arvalid_o), 1);
        done = 1'b1;
      end
      tick();
    end
    s_arvalid_i = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL ar_timeout: id=%0h actual=no_arready required=arready", id);
    end
  endtask

  task automatic send_beat(input logic [1:0] tag, input logic [7:0] data,
                           input logic [1:0] resp, input logic last);
    m_rid_i    = tag;
    m_rdata_i  = data;
    m_rresp_i  = resp;
    m_rlast_i  = last;
    m_rvalid_i = 1'b1;
    tick();
    m_rvalid_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: actual=%0d beats pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Slave-side monitor: inputs only change just after posedge, so the negedge view is the handshake.
  always @(negedge clk) begin
    if (rst_n && s_rvalid_o && s_rready_i) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: actual rid=%0h data=%0h required=no beat", s_rid_o, s_rdata_o);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("rbeat{id,resp,last,data}", 32'({s_rid_o, s_rresp_o, s_rlast_o, s_rdata_o}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{id: 4'h8, data: 8'hC1, resp: RESP_OKAY,   tag: 2'd3};
    tbl[1] = '{id: 4'h9, data: 8'hC2, resp: RESP_SLVERR, tag: 2'd0};
    tbl[2] = '{id: 4'hA, data: 8'hC3, resp: RESP_OKAY,   tag: 2'd1};
    tbl[3] = '{id: 4'hB, data: 8'hC4, resp: RESP_OKAY,   tag: 2'd2};

    s_arid_i = '0; s_arlen_i = '0; s_arvalid_i = 1'b1; s_rready_i = 1'b1;
    m_arready_i = 1'b1; m_rdata_i = '0; m_rresp_i = '0; m_rid_i = '0;
    m_rlast_i = 1'b0; m_rvalid_i = 1'b0;

    // Reset values, with AR valid/ready asserted to show gating.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ar{s_arready,m_arvalid,m_rready}", 32'({s_arready_o, m_arvalid_o, m_rready_o}), 0);
    chk("rst_r{rvalid,rlast,err}", 32'({s_rvalid_o, s_rlast_o, err_o}), 0);
    chk("rst_payload", 32'({s_rdata_o, s_rid_o, s_rresp_o, m_arid_o}), 0);
    s_arvalid_i = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("m_rready_live", 32'(m_rready_o), 1);

    // In-order single beats.
    push_exp(4'h2, 8'hFE, RESP_OKAY, 1'b1);
    push_exp(4'h3, 8'hBF, RESP_OKAY, 1'b1);
    do_ar(4'h2, 2'd0, 2'd0);
    do_ar(4'h3, 2'd0, 2'd1);
    send_beat(2'd0, 8'hFE, RESP_OKAY, 1'b1);
    send_beat(2'd1, 8'hBF, RESP_OKAY, 1'b1);
    drain();
    chk("err_inorder", 32'(err_o), 0);

    // Out-of-order: later slots complete before the head.
    push_exp(4'h4, 8'h0A, RESP_OKAY, 1'b1);
    push_exp(4'h5, 8'h80, RESP_OKAY, 1'b1);
    push_exp(4'h6, 8'h70, RESP_OKAY, 1'b1);
    do_ar(4'h4, 2'd0, 2'd2);
    do_ar(4'h5, 2'd0, 2'd3);
    do_ar(4'h6, 2'd0, 2'd0);
    send_beat(2'd0, 8'h70, RESP_OKAY, 1'b1);
    send_beat(2'd3, 8'h80, RESP_OKAY, 1'b1);
    chk("ooo_head_blocks", 32'(s_rvalid_o), 0);
    send_beat(2'd2, 8'h0A, RESP_OKAY, 1'b1);
    drain();

    // Interleaved bursts.
    push_exp(4'h1, 8'h10, RESP_OKAY,   1'b0);
    push_exp(4'h1, 8'h11, RESP_OKAY,   1'b0);
    push_exp(4'h1, 8'h12, RESP_SLVERR, 1'b0);
    push_exp(4'h1, 8'h13, RESP_OKAY,   1'b1);
    push_exp(4'h7, 8'h20, RESP_OKAY,   1'b0);
    push_exp(4'h7, 8'h21, RESP_OKAY,   1'b1);
    do_ar(4'h1, 2'd3, 2'd1);
    do_ar(4'h7, 2'd1, 2'd2);
    send_beat(2'd1, 8'h10, RESP_OKAY,   1'b0);
    send_beat(2'd2, 8'h20, RESP_OKAY,   1'b0);
    send_beat(2'd1, 8'h11, RESP_OKAY,   1'b0);
    send_beat(2'd2, 8'h21, RESP_OKAY,   1'b1);
    send_beat(2'd1, 8'h12, RESP_SLVERR, 1'b0);
    send_beat(2'd1, 8'h13, RESP_OKAY,   1'b1);
    drain();
    chk("err_bursts", 32'(err_o), 0);

    // Table: fill all slots, check full, deliver in reverse under backpressure.
    for (int i = 0; i < 4; i++) begin
      push_exp(tbl[i].id, tbl[i].data, tbl[i].resp, 1'b1);
      do_ar(tbl[i].id, 2'd0, tbl[i].tag);
    end
    s_arid_i = 4'hF;
    s_arlen_i = 2'd0;
    s_arvalid_i = 1'b1;
    #1;
    chk("full_s_arready", 32'(s_arready_o), 0);
    chk("full_m_arvalid", 32'(m_arvalid_o), 0);
    s_rready_i = 1'b0;
    for (int i = 3; i >= 0; i--) send_beat(tbl[i].tag, tbl[i].data, tbl[i].resp, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("stall_rvalid", 32'(s_rvalid_o), 1);
      chk("stall_payload{id,data,resp,last}", 32'({s_rid_o, s_rdata_o, s_rresp_o, s_rlast_o}),
          32'({tbl[0].id, tbl[0].data, tbl[0].resp, 1'b1}));
      tick();
    end
    s_rready_i = 1'b1;
    #1;
    chk("full_no_bypass", 32'(s_arready_o), 0);
    tick();
    chk("arready_after_retire", 32'(s_arready_o), 1);
    s_arvalid_i = 1'b0;
    drain();

    // Beat to an empty slot, then an rlast mismatch; both dropped, err sticky.
    send_beat(2'd3, 8'h55, RESP_OKAY, 1'b1);
    chk("err_set", 32'(err_o), 1);
    chk("bad_beat_dropped", 32'(s_rvalid_o), 0);
    tick();
    chk("err_sticky", 32'(err_o), 1);
    push_exp(4'hC, 8'h77, RESP_OKAY, 1'b0);
    push_exp(4'hC, 8'h78, RESP_OKAY, 1'b1);
    do_ar(4'hC, 2'd1, 2'd3);
    send_beat(2'd3, 8'h66, RESP_OKAY, 1'b1);
    chk("rlast_mismatch_dropped", 32'(s_rvalid_o), 0);
    send_beat(2'd3, 8'h77, RESP_OKAY, 1'b0);
    send_beat(2'd3, 8'h78, RESP_OKAY, 1'b1);
    drain();
    chk("err_still_set", 32'(err_o), 1);

    // Asynchronous reset mid-burst.
    do_ar(4'h5, 2'd3, 2'd0);
    s_rready_i = 1'b0;
    send_beat(2'd0, 8'hA0, RESP_OKAY, 1'b0);
    send_beat(2'd0, 8'hA1, RESP_OKAY, 1'b0);
    chk("pre_reset_rvalid", 32'(s_rvalid_o), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl{rvalid,rlast,err,m_rready,s_arready,m_arvalid}",
        32'({s_rvalid_o, s_rlast_o, err_o, m_rready_o, s_arready_o, m_arvalid_o}), 0);
    chk("midrst_payload", 32'({s_rdata_o, s_rid_o, s_rresp_o, m_arid_o}), 0);
    tick();
    rst_n = 1'b1;
    s_rready_i = 1'b1;
    tick();
    push_exp(4'hD, 8'hB5, RESP_OKAY, 1'b1);
    do_ar(4'hD, 2'd0, 2'd0);
    send_beat(2'd0, 8'hB5, RESP_OKAY, 1'b1);
    drain();
    chk("err_after_reset", 32'(err_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
